// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: round-robin arbiter and sequencer between two load/store
// requesters and a single APB master.
//
// Ports
//   PCLK, PRESETn              clock; synchronous active-high reset
//   rX_req/wr/addr/wdata/strb  requester X (0 = CPU data stage, 1 = UART/DMA)
//   rX_gnt                     same-cycle accept pulse (IDLE only)
//   rX_done                    one-cycle completion pulse to the owning port
//   rsp_err, rsp_rdata         response status/data, valid with rX_done
//   m_transEn, m_wr_en, m_addr, m_wdata, m_strobe   master request bus
//   m_done, m_rdata            master completion and read data
//   busy                       high while a transfer is in BUSY or RESP
module apb_req_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              r0_req,
  input  logic              r0_wr,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  input  logic [1:0]        r0_strb,
  input  logic              r1_req,
  input  logic              r1_wr,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  input  logic [1:0]        r1_strb,
  output logic              r0_gnt,
  output logic              r1_gnt,
  output logic              r0_done,
  output logic              r1_done,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              m_transEn,
  output logic              m_wr_en,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic [1:0]        m_strobe,
  input  logic              m_done,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              busy
);

  // A zero TIMEOUT still needs a 1-bit counter to keep widths legal.
  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit          TMO_EN = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              last_q;      // port granted most recently
  logic              owner_q;     // port owning the current transfer
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [1:0]        strb_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic [CNT_W-1:0]  cnt_q;

  logic win1;      // port 1 wins arbitration this cycle
  logic grant;     // a grant is issued this cycle
  logic tmo_hit;   // current BUSY cycle is the last one allowed

  // Round-robin: on a tie the port not granted last wins.
  assign win1    = (r0_req && r1_req) ? ~last_q : r1_req;
  assign grant   = (state_q == ST_IDLE) && (r0_req || r1_req) && !PRESETn;
  assign tmo_hit = TMO_EN && (cnt_q == CNT_LAST);

  // State register
  always_ff @(posedge PCLK) begin
    if (PRESETn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (grant) state_d = ST_BUSY;
      ST_BUSY: if (m_done || tmo_hit) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Request latches, response latches and timeout counter
  always_ff @(posedge PCLK) begin
    if (PRESETn) begin
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant) begin
            owner_q <= win1;
            last_q  <= win1;
            wr_q    <= win1 ? r1_wr    : r0_wr;
            addr_q  <= win1 ? r1_addr  : r0_addr;
            wdata_q <= win1 ? r1_wdata : r0_wdata;
            strb_q  <= win1 ? r1_strb  : r0_strb;
            cnt_q   <= '0;
          end
        end
        ST_BUSY: begin
          // m_done takes priority over a coincident timeout.
          if (m_done) begin
            rdata_q <= wr_q ? '0 : m_rdata;
            err_q   <= 1'b0;
          end else if (tmo_hit) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode
  always_comb begin
    r0_gnt    = 1'b0;
    r1_gnt    = 1'b0;
    r0_done   = 1'b0;
    r1_done   = 1'b0;
    rsp_err   = 1'b0;
    rsp_rdata = '0;
    m_transEn = 1'b0;
    busy      = 1'b0;
    m_wr_en   = wr_q;
    m_addr    = addr_q;
    m_wdata   = wdata_q;
    m_strobe  = strb_q;
    case (state_q)
      ST_IDLE: begin
        r0_gnt = grant && !win1;
        r1_gnt = grant && win1;
      end
      ST_BUSY: begin
        m_transEn = 1'b1;
        busy      = 1'b1;
      end
      ST_RESP: begin
        busy      = 1'b1;
        r0_done   = !owner_q;
        r1_done   = owner_q;
        rsp_err   = err_q;
        rsp_rdata = rdata_q;
      end
      default: ;
    endcase
  end

endmodule
